// File: rtl/load_resp_unit.sv
// load_resp_unit: takes one decoded load from the MEM stage and issues it on
// the SRAM-like data bus. It then aligns, extends or merges the returned word
// into a writeback value, and holds the pipeline while the load is in flight.
//
// Handshake semantics:
//   MEM side: a load is taken on a cycle with ld_valid & ld_ready & ~flush
//     and a legal load type. ld_ready is high only in IDLE.
//   Bus address phase: data_req stays high, with data_addr and data_size
//     stable, until the cycle in which data_addr_ok is sampled high.
//   Bus data phase: the single data_data_ok beat is always absorbed, even when
//     a flush has killed the load. A killed load drops its result silently.
//   Writeback: wb_valid is a one-cycle pulse. wb_data and wb_dst are only
//     meaningful in that cycle.
module load_resp_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [8:0]        ld_ext_type,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_old_rt,
    input  logic [4:0]        ld_dst,
    input  logic              flush,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output logic              stall,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_dst,
    output logic [1:0]        dbg_state
);

    // IDLE is encoded as zero so that a debug probe reading 0 means "free".
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   killed_q, killed_d;

    // The latched load. ext_q keeps only the load bits {lb,lbu,lh,lhu,lw,lwl,lwr}.
    logic [6:0]        ext_q;
    logic [1:0]        off_q;
    logic [31:0]       old_q;
    logic [4:0]        dst_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wb_data_q;
    logic [4:0]        wb_dst_q;

    logic [6:0]        ld_bits;
    logic              type_ok;
    logic              accept;
    logic              complete;
    logic              is_lwlr;
    logic [ADDR_W-1:0] bus_addr;
    logic [1:0]        bus_size;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;
    logic [31:0]       result;

    // Decode the incoming request: legality, bus address and bus size.
    always_comb begin
        ld_bits  = ld_ext_type[8:2];
        // Exactly one load bit and no store bit. Anything else is not a load.
        type_ok  = (ld_ext_type[1:0] == 2'b00) && (ld_bits != 7'd0) &&
                   ((ld_bits & (ld_bits - 7'd1)) == 7'd0);
        accept   = (state_q == S_IDLE) && ld_valid && !flush && type_ok;
        is_lwlr  = ld_ext_type[3] | ld_ext_type[2];
        bus_addr = is_lwlr ? {ld_addr[ADDR_W-1:2], 2'b00} : ld_addr;
        if (ld_ext_type[8] | ld_ext_type[7]) begin
            bus_size = 2'd0;
        end else if (ld_ext_type[6] | ld_ext_type[5]) begin
            bus_size = 2'd1;
        end else begin
            bus_size = 2'd2;
        end
        // A beat that arrives with a flush in the same cycle counts as killed.
        complete = (state_q == S_WAIT) && data_data_ok && !killed_q && !flush;
    end

    // Align, extend or merge the returned word according to the latched type.
    always_comb begin
        sel_byte = data_rdata[{off_q, 3'b000} +: 8];
        sel_half = off_q[1] ? data_rdata[31:16] : data_rdata[15:0];
        result   = 32'd0;
        if (ext_q[6]) begin
            result = {{24{sel_byte[7]}}, sel_byte};
        end else if (ext_q[5]) begin
            result = {24'd0, sel_byte};
        end else if (ext_q[4]) begin
            result = {{16{sel_half[15]}}, sel_half};
        end else if (ext_q[3]) begin
            result = {16'd0, sel_half};
        end else if (ext_q[2]) begin
            result = data_rdata;
        end else if (ext_q[1]) begin
            case (off_q)
                2'd0:    result = {data_rdata[7:0],  old_q[23:0]};
                2'd1:    result = {data_rdata[15:0], old_q[15:0]};
                2'd2:    result = {data_rdata[23:0], old_q[7:0]};
                default: result = data_rdata;
            endcase
        end else if (ext_q[0]) begin
            case (off_q)
                2'd0:    result = data_rdata;
                2'd1:    result = {old_q[31:24], data_rdata[31:8]};
                2'd2:    result = {old_q[31:16], data_rdata[31:16]};
                default: result = {old_q[31:8],  data_rdata[31:24]};
            endcase
        end
    end

    // State register and kill flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            killed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            killed_q <= killed_d;
        end
    end

    // Next-state logic. A flush can never abort an accepted address phase,
    // because the data beat still has to be drained from the bus.
    always_comb begin
        state_d  = state_q;
        killed_d = killed_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_REQ;
                    killed_d = 1'b0;
                end
            end
            S_REQ: begin
                if (data_addr_ok) begin
                    state_d  = S_WAIT;
                    killed_d = flush;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    killed_d = 1'b1;
                end
                if (data_data_ok) begin
                    state_d = (killed_q || flush) ? S_IDLE : S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Load capture at the handshake, and result capture when the beat returns.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_q     <= 7'd0;
            off_q     <= 2'd0;
            old_q     <= 32'd0;
            dst_q     <= 5'd0;
            addr_q    <= '0;
            size_q    <= 2'd0;
            wb_data_q <= 32'd0;
            wb_dst_q  <= 5'd0;
        end else begin
            if (accept) begin
                ext_q  <= ld_bits;
                off_q  <= ld_addr[1:0];
                old_q  <= ld_old_rt;
                dst_q  <= ld_dst;
                addr_q <= bus_addr;
                size_q <= bus_size;
            end
            if (complete) begin
                wb_data_q <= result;
                wb_dst_q  <= dst_q;
            end
        end
    end

    // Outputs depend on state only. stall drops in DONE so that the pipeline
    // restarts in the same cycle as the writeback pulse.
    always_comb begin
        ld_ready  = (state_q == S_IDLE);
        data_req  = (state_q == S_REQ);
        data_wr   = 1'b0;
        data_addr = addr_q;
        data_size = size_q;
        stall     = (state_q == S_REQ) || (state_q == S_WAIT);
        wb_valid  = (state_q == S_DONE);
        wb_data   = wb_data_q;
        wb_dst    = wb_dst_q;
        dbg_state = state_q;
    end

endmodule

// File: doc/load_resp_unit.md
Name: load_resp_unit

Overview:
- Load-side counterpart to the execute-stage memory control decode. It accepts one decoded load per request and issues it on the SRAM-like data bus (addr_ok/data_ok handshake).
- It collects the returned word, then aligns, extends or merges it (lb/lbu/lh/lhu/lw/lwl/lwr) into a writeback value.
- It sits between the MEM stage and the data bus, and stalls the pipeline while a load is outstanding.

Parameters:
- ADDR_W, 32, data bus address width.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ld_valid  in  1  MEM stage presents a load this cycle
- ld_ready  out  1  unit can accept ld_valid (high only in IDLE)
- ld_ext_type  in  9  one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr}; only bits 8:2 are meaningful here
- ld_addr  in  ADDR_W  full effective address
- ld_old_rt  in  32  current rt value, used for the lwl/lwr merge
- ld_dst  in  5  destination register
- flush  in  1  exception/eret flush from the commit point
- data_req  out  1  bus request
- data_wr  out  1  always 0
- data_size  out  2  0=byte, 1=half, 2=word
- data_addr  out  ADDR_W  bus address
- data_addr_ok  in  1  bus accepted the request
- data_data_ok  in  1  read data valid
- data_rdata  in  32  read data, little-endian word
- stall  out  1  pipeline hold request
- wb_valid  out  1  result valid, one-cycle pulse
- wb_data  out  32  aligned/extended/merged result
- wb_dst  out  5  destination register of wb_data

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE.
  - data_req=0, wb_valid=0, wb_data=0, wb_dst=0, stall=0, data_addr=0, data_size=0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - ld_ready=1.
  - A handshake (ld_valid & ~flush) with exactly one of bits 8:2 set latches ext_type, offset=ld_addr[1:0], old_rt and dst, then goes to REQ.
  - data_addr = ld_addr for lb/lbu/lh/lhu/lw; {ld_addr[ADDR_W-1:2],2'b00} for lwl/lwr.
  - data_size: lb/lbu→0, lh/lhu→1, lw/lwl/lwr→2.
  - Any other ext_type (zero, store bits only, or multi-hot) is ignored; the state stays IDLE.
- REQ:
  - data_req=1, with data_addr and data_size held stable.
  - On data_addr_ok, go to WAIT.
  - On flush with no addr_ok in that cycle, drop data_req and return to IDLE.
  - If addr_ok and flush coincide, go to WAIT with the killed flag set.
- WAIT:
  - data_req=0.
  - On data_data_ok, compute the result and go to DONE; if killed, go straight to IDLE instead.
  - A flush in WAIT sets killed. The data beat must still be absorbed and discarded; it is never aborted.
- DONE:
  - wb_valid=1 for exactly one cycle with wb_data/wb_dst registered.
  - Then IDLE. No flush suppression in DONE, because the load has already committed past the flush point.
- stall = (state != IDLE) & ~(state==DONE). This releases the pipeline in the same cycle as wb_valid.
- Result rules, with b=offset and r=data_rdata:
  - lb: sign-extend r[8b+7:8b].
  - lbu: zero-extend r[8b+7:8b].
  - lh: sign-extend r[16b[1]+15:16b[1]].
  - lhu: zero-extend r[16b[1]+15:16b[1]].
  - lw: r.
  - lwl, by offset: 0→{r[7:0],old[23:0]}; 1→{r[15:0],old[15:0]}; 2→{r[23:0],old[7:0]}; 3→r.
  - lwr, by offset: 0→r; 1→{old[31:24],r[31:8]}; 2→{old[31:16],r[31:16]}; 3→{old[31:8],r[31:24]}.
- Alignment faults are filtered before this block; misaligned lw/lh addresses are not re-checked here.
- data_data_ok arriving in IDLE, REQ or DONE is ignored.
- Latency: handshake to wb_valid = 3 cycles, given addr_ok in the first REQ cycle and data_ok the cycle after.
- Reset mid-transaction returns to IDLE immediately. Outstanding bus beats after reset are the bus's responsibility.

Test Plan:
- lb, addr 0x1003, rdata 0x80_12_34_56 → data_size=0, data_addr=0x1003, wb_data=0xFFFFFF80; lbu with the same inputs → 0x00000080.
- lh, addr 0x2002, rdata 0x8001_7FFF → wb_data=0xFFFF8001; lhu → 0x00008001.
- lwl, addr 0x3001, old_rt 0xAABBCCDD, rdata 0x11223344 → data_addr=0x3000, size=2, wb_data=0x3344CCDD; lwr at offset 1 → 0xAA112233.
- addr_ok held low 5 cycles → data_req stays 1 with the address stable and stall=1 throughout; wb_valid is a single pulse after data_ok.
- Flush asserted in WAIT, then data_ok 2 cycles later → no wb_valid, unit returns to IDLE with ld_ready=1; the next load completes normally.
- Flush in REQ before addr_ok → data_req drops next cycle and no beat is expected; ld_ext_type=swl only → no request, stays IDLE.
